pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - fetch PC sequencer with stall hold and prioritised redirect buffering
// Optional feature macro: PC_SEQ_CTRL_ALIGN_CHK_EN (misaligned redirect targets trap to EXC_VEC).
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'hBFC00000,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] saved_pc,
  output logic        pc_stall,
  output logic        flush,
  output logic        redir_pend,
  output logic        align_exc,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

  // Redirect priorities; larger value wins, PRI_NONE means no redirect.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_ERET = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [1:0]  pend_pri_q, pend_pri_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        flush_q, flush_d;
  logic        align_exc_q, align_exc_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;

  logic [1:0]  live_pri;
  logic [31:0] live_tgt;
  logic [1:0]  sel_pri;
  logic [31:0] sel_tgt;
  logic [31:0] load_tgt;
  logic        load_misal;
  logic        load;

  // Highest-priority redirect presented this cycle (raw, unchecked target).
  always_comb begin
    live_pri = PRI_NONE;
    live_tgt = br_target;
    if (exc_valid) begin
      live_pri = PRI_EXC;
      live_tgt = EXC_VEC;
    end else if (eret_valid) begin
      live_pri = PRI_ERET;
      live_tgt = epc;
    end else if (br_valid) begin
      live_pri = PRI_BR;
      live_tgt = br_target;
    end
  end

  // Pending buffer only beats a live redirect when strictly higher priority.
  always_comb begin
    sel_pri = live_pri;
    sel_tgt = live_tgt;
    if ((state_q == HOLD_PEND) && (pend_pri_q > live_pri)) begin
      sel_pri = pend_pri_q;
      sel_tgt = pend_tgt_q;
    end
  end

  // Alignment handling of the selected branch/eret target.
  always_comb begin
    load_tgt   = sel_tgt;
    load_misal = 1'b0;
    if ((sel_pri == PRI_BR) || (sel_pri == PRI_ERET)) begin
`ifdef PC_SEQ_CTRL_ALIGN_CHK_EN
      if (sel_tgt[1:0] != 2'b00) begin
        load_misal = 1'b1;
        load_tgt   = EXC_VEC;
      end
`else
      load_tgt = {sel_tgt[31:2], 2'b00};
`endif
    end
  end

  // Next-state logic: hold during stalls, buffer redirects, load pc when fetch proceeds.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    saved_pc_d  = saved_pc_q;
    pend_pri_d  = pend_pri_q;
    pend_tgt_d  = pend_tgt_q;
    flush_d     = 1'b0;
    align_exc_d = 1'b0;
    bad_vaddr_d = bad_vaddr_q;
    load        = 1'b0;
    case (state_q)
      RUN: begin
        if (stall_i) begin
          saved_pc_d = pc_q;
          if (live_pri != PRI_NONE) begin
            pend_pri_d = live_pri;
            pend_tgt_d = live_tgt;
            state_d    = HOLD_PEND;
          end else begin
            state_d = HOLD;
          end
        end else begin
          load = 1'b1;
        end
      end
      HOLD, HOLD_PEND: begin
        if (stall_i) begin
          // pend_pri_q is PRI_NONE in HOLD, so any live redirect is taken there.
          if ((live_pri != PRI_NONE) && (live_pri >= pend_pri_q)) begin
            pend_pri_d = live_pri;
            pend_tgt_d = live_tgt;
            state_d    = HOLD_PEND;
          end
        end else begin
          load       = 1'b1;
          pend_pri_d = PRI_NONE;
          state_d    = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        pend_pri_d = PRI_NONE;
      end
    endcase
    if (load) begin
      if (sel_pri != PRI_NONE) begin
        pc_d        = load_tgt;
        flush_d     = 1'b1;
        align_exc_d = load_misal;
        if (load_misal) bad_vaddr_d = sel_tgt;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // State registers with synchronous reset that discards any buffered redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_VEC;
      saved_pc_q  <= RESET_VEC;
      pend_pri_q  <= PRI_NONE;
      pend_tgt_q  <= 32'd0;
      flush_q     <= 1'b0;
      align_exc_q <= 1'b0;
      bad_vaddr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      saved_pc_q  <= saved_pc_d;
      pend_pri_q  <= pend_pri_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_q     <= flush_d;
      align_exc_q <= align_exc_d;
      bad_vaddr_q <= bad_vaddr_d;
    end
  end

  assign pc         = pc_q;
  assign saved_pc   = saved_pc_q;
  assign pc_stall   = (state_q != RUN);
  assign redir_pend = (state_q == HOLD_PEND);
  assign flush      = flush_q;
  assign align_exc  = align_exc_q;
  assign bad_vaddr  = bad_vaddr_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - table-driven self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

`ifdef PC_SEQ_CTRL_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, br_valid, exc_valid, eret_valid;
  logic [31:0] br_target, epc;
  logic [31:0] pc, saved_pc, bad_vaddr;
  logic        pc_stall, flush, redir_pend, align_exc;

  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc),
    .pc(pc), .saved_pc(saved_pc), .pc_stall(pc_stall), .flush(flush),
    .redir_pend(redir_pend), .align_exc(align_exc), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] brt;
    logic        exc, eret;
    logic [31:0] epc;
    logic [31:0] e_pc, e_saved;
    logic        e_st, e_fl, e_pd, e_ae;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, s, b, input logic [31:0] bt, input logic x, e,
                     input logic [31:0] ep, input logic [31:0] xpc, xsv,
                     input logic st, fl, pd, ae, input logic [31:0] bad);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.brt = bt; v.exc = x; v.eret = e; v.epc = ep;
    v.e_pc = xpc; v.e_saved = xsv; v.e_st = st; v.e_fl = fl; v.e_pd = pd;
    v.e_ae = ae; v.e_bad = bad;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, b, input logic [31:0] bt, input logic x, e,
                       input logic [31:0] ep);
    rst = r; stall_i = s; br_valid = b; br_target = bt;
    exc_valid = x; eret_valid = e; epc = ep;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; br_valid = 1'b0; br_target = 32'd0;
    exc_valid = 1'b0; eret_valid = 1'b0; epc = 32'd0;

    //   rst stl br brt           exc eret epc          | pc            saved         st fl pd ae bad
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00000, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00004, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00008, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC0000C, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00010, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00010, 32'hBFC00010, 1, 0, 0, 0, 32'h0);
    add(0, 1, 1, 32'h80001000, 0, 0, 32'h0,        32'hBFC00010, 32'hBFC00010, 1, 0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00010, 32'hBFC00010, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h80001000, 32'hBFC00010, 0, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h80001004, 32'hBFC00010, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 32'h80002000, 1, 1, 32'h80000200, 32'hBFC00380, 32'hBFC00010, 0, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00384, 32'hBFC00010, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 32'h80003000, 0, 0, 32'h0,        32'hBFC00384, 32'hBFC00384, 1, 0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'hBFC00384, 32'hBFC00384, 1, 0, 1, 0, 32'h0);
    add(0, 1, 1, 32'h80004000, 0, 0, 32'h0,        32'hBFC00384, 32'hBFC00384, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00380, 32'hBFC00384, 0, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00384, 32'hBFC00384, 0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,        0, 1, 32'h80000200, 32'hBFC00384, 32'hBFC00384, 1, 0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000300, 32'h80000300, 32'hBFC00384, 0, 1, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,        0, 1, 32'h80000400, 32'h80000300, 32'h80000300, 1, 0, 1, 0, 32'h0);
    add(0, 0, 1, 32'h80005000, 0, 0, 32'h0,        32'h80000400, 32'h80000300, 0, 1, 0, 0, 32'h0);
    add(0, 1, 1, 32'h80006000, 0, 0, 32'h0,        32'h80000400, 32'h80000400, 1, 0, 1, 0, 32'h0);
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00000, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00004, 32'hBFC00000, 0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hBFC00004, 32'hBFC00004, 1, 0, 0, 0, 32'h0);
    add(0, 0, 1, 32'h80007000, 0, 0, 32'h0,        32'h80007000, 32'hBFC00004, 0, 1, 0, 0, 32'h0);
    add(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        32'hFFFFFFFC, 32'hBFC00004, 0, 1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h00000000, 32'hBFC00004, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h00000004, 32'hBFC00004, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 32'h80001002, 0, 0, 32'h0,        ALN ? 32'hBFC00380 : 32'h80001000, 32'hBFC00004,
        0, 1, 0, ALN, ALN ? 32'h80001002 : 32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        ALN ? 32'hBFC00384 : 32'h80001004, 32'hBFC00004,
        0, 0, 0, 0, ALN ? 32'h80001002 : 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000203, ALN ? 32'hBFC00380 : 32'h80000200, 32'hBFC00004,
        0, 1, 0, ALN, ALN ? 32'h80000203 : 32'h0);
    add(0, 0, 1, 32'h80008000, 0, 0, 32'h0,        32'h80008000, 32'hBFC00004,
        0, 1, 0, 0, ALN ? 32'h80000203 : 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].br, vq[i].brt, vq[i].exc, vq[i].eret, vq[i].epc);
      chk($sformatf("v%0d pc", i),         pc,                 vq[i].e_pc);
      chk($sformatf("v%0d saved_pc", i),   saved_pc,           vq[i].e_saved);
      chk($sformatf("v%0d pc_stall", i),   {31'd0, pc_stall},  {31'd0, vq[i].e_st});
      chk($sformatf("v%0d flush", i),      {31'd0, flush},     {31'd0, vq[i].e_fl});
      chk($sformatf("v%0d redir_pend", i), {31'd0, redir_pend}, {31'd0, vq[i].e_pd});
      chk($sformatf("v%0d align_exc", i),  {31'd0, align_exc}, {31'd0, vq[i].e_ae});
      chk($sformatf("v%0d bad_vaddr", i),  bad_vaddr,          vq[i].e_bad);
    end

    // Reset held two cycles while redirects are asserted: reset wins, no flush, bad_vaddr cleared.
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 32'h80009000, 1, 0, 32'h0);
      chk($sformatf("rst_hold%0d pc", k), pc, 32'hBFC00000);
      chk($sformatf("rst_hold%0d flush", k), {31'd0, flush}, 32'd0);
      chk($sformatf("rst_hold%0d bad_vaddr", k), bad_vaddr, 32'd0);
      chk($sformatf("rst_hold%0d pc_stall", k), {31'd0, pc_stall}, 32'd0);
    end

    // Equal-priority branch overwrites the pending one across a long stall.
    drive(0, 1, 1, 32'h80009000, 0, 0, 32'h0);
    chk("eq_pend redir_pend", {31'd0, redir_pend}, 32'd1);
    drive(0, 1, 1, 32'h8000A000, 0, 0, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
    chk("eq_pend pc_hold", pc, 32'hBFC00000);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("eq_pend pc", pc, 32'h8000A000);
    chk("eq_pend flush", {31'd0, flush}, 32'd1);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("eq_pend after pc", pc, 32'h8000A004);
    chk("eq_pend after flush", {31'd0, flush}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
